hwag_tooth_tracker: RTL and testbench

Trigger-wheel tooth tracker that sits directly downstream of the VR capture/filter stage. It consumes the filtered single-cycle edge pulse, measures the period between consecutive teeth, and finds the missing-tooth gap. It then maintains a tooth counter locked to the gap and reports sync loss. Its outputs feed the angle-generation (pcnt) stage and the interrupt flag register.

---
 rtl/hwag_pkg.sv | 15 +
 rtl/hwag_period_timer.sv | 39 +++
 rtl/hwag_tooth_tracker.sv | 161 ++++++++++++++++
 tb/tb_hwag_tooth_tracker.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/hwag_pkg.sv
// Shared types and default widths for the HWAG trigger-wheel blocks.
package hwag_pkg;

  localparam int unsigned HWAG_CNT_W  = 24;
  localparam int unsigned HWAG_TCNT_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FIRST,
    MEASURE,
    HUNT,
    SYNC
  } tt_state_t;

endpackage

// File: rtl/hwag_period_timer.sv
// Tooth period timer: load-1 on an accepted edge, count up, stick at all-ones.
module hwag_period_timer #(
  parameter int unsigned CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             run,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  logic [CNT_W-1:0] cnt_d;

  // Next count: clear beats load beats increment; increment stops at all-ones.
  always_comb begin
    cnt_d = cnt;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = CNT_W'(1);
    end else if (run && !sat) begin
      cnt_d = cnt + CNT_W'(1);
    end
  end

  // Count register; sat is registered alongside so it tracks cnt exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      sat <= 1'b0;
    end else begin
      cnt <= cnt_d;
      sat <= &cnt_d;
    end
  end

endmodule

// File: rtl/hwag_tooth_tracker.sv
// Tooth tracker: measures tooth periods, finds the missing-tooth gap and
// keeps a tooth index locked to it, flagging gap mismatches and stalls.
module hwag_tooth_tracker
  import hwag_pkg::*;
#(
  parameter int unsigned CNT_W  = HWAG_CNT_W,
  parameter int unsigned TCNT_W = HWAG_TCNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              edge_in,
  input  logic [TCNT_W-1:0] tooth_max,
  output logic [CNT_W-1:0]  period,
  output logic [CNT_W-1:0]  period_ref,
  output logic [TCNT_W-1:0] tooth_cnt,
  output logic              sync,
  output logic              tooth_evt,
  output logic              gap_evt,
  output logic              err_evt,
  output logic              stall_evt
);

  tt_state_t         state_q, state_d;
  logic [CNT_W-1:0]  period_d, ref_d;
  logic [TCNT_W-1:0] cnt_d;
  logic              tooth_evt_d, gap_evt_d, err_evt_d, stall_evt_d;
  logic              tmr_clr, tmr_load, tmr_run, tmr_sat;
  logic [CNT_W-1:0]  tmr_cnt;
  logic [CNT_W:0]    gap_lim;
  logic              is_gap;

  hwag_period_timer #(.CNT_W(CNT_W)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (tmr_clr),
    .load (tmr_load),
    .run  (tmr_run),
    .cnt  (tmr_cnt),
    .sat  (tmr_sat)
  );

  // Timer runs whenever the tracker is active; it holds while disabled.
  assign tmr_run = ena && (state_q != IDLE);

  // Gap when the current period exceeds 1.5x the reference (one extra bit, no overflow).
  assign gap_lim = (CNT_W+1)'(period_ref) + (CNT_W+1)'(period_ref >> 1);
  assign is_gap  = (CNT_W+1)'(tmr_cnt) > gap_lim;

  // Next-state, register updates and event pulses.
  always_comb begin
    state_d     = state_q;
    period_d    = period;
    ref_d       = period_ref;
    cnt_d       = tooth_cnt;
    tooth_evt_d = 1'b0;
    gap_evt_d   = 1'b0;
    err_evt_d   = 1'b0;
    stall_evt_d = 1'b0;
    tmr_clr     = 1'b0;
    tmr_load    = 1'b0;

    if (!ena) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d  = WAIT_FIRST;
          tmr_clr  = 1'b1;
          period_d = '0;
          ref_d    = '0;
          cnt_d    = '0;
        end
        WAIT_FIRST: begin
          if (edge_in) begin
            state_d  = MEASURE;
            tmr_load = 1'b1;
          end
        end
        default: begin
          if (tmr_sat) begin
            // Engine stopped; an edge landing here restarts as the reference edge.
            stall_evt_d = 1'b1;
            if (edge_in) begin
              state_d  = MEASURE;
              tmr_load = 1'b1;
            end else begin
              state_d = WAIT_FIRST;
            end
          end else if (edge_in) begin
            tmr_load    = 1'b1;
            tooth_evt_d = 1'b1;
            period_d    = tmr_cnt;
            case (state_q)
              MEASURE: begin
                state_d = HUNT;
                ref_d   = tmr_cnt;
              end
              HUNT: begin
                if (is_gap) begin
                  state_d   = SYNC;
                  cnt_d     = '0;
                  gap_evt_d = 1'b1;
                end else begin
                  ref_d = tmr_cnt;
                end
              end
              SYNC: begin
                if (is_gap) begin
                  if (tooth_cnt == tooth_max) begin
                    cnt_d     = '0;
                    gap_evt_d = 1'b1;
                  end else begin
                    err_evt_d = 1'b1;
                    state_d   = HUNT;
                  end
                end else begin
                  ref_d = tmr_cnt;
                  // Also catches a tooth_max lowered below the current index.
                  if (tooth_cnt >= tooth_max) begin
                    err_evt_d = 1'b1;
                    state_d   = HUNT;
                  end else begin
                    cnt_d = tooth_cnt + TCNT_W'(1);
                  end
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      period     <= '0;
      period_ref <= '0;
      tooth_cnt  <= '0;
      sync       <= 1'b0;
      tooth_evt  <= 1'b0;
      gap_evt    <= 1'b0;
      err_evt    <= 1'b0;
      stall_evt  <= 1'b0;
    end else begin
      state_q    <= state_d;
      period     <= period_d;
      period_ref <= ref_d;
      tooth_cnt  <= cnt_d;
      sync       <= (state_d == SYNC);
      tooth_evt  <= tooth_evt_d;
      gap_evt    <= gap_evt_d;
      err_evt    <= err_evt_d;
      stall_evt  <= stall_evt_d;
    end
  end

endmodule

// File: tb/tb_hwag_tooth_tracker.sv
// Directed bench for hwag_tooth_tracker: 60-2 wheel lock, gap errors,
// threshold boundary, enable drop, and timer stall on an 8-bit instance.
module tb_hwag_tooth_tracker;
  import hwag_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena, edge_in;
  logic [7:0]  tooth_max;
  logic [23:0] period, period_ref;
  logic [7:0]  tooth_cnt;
  logic        sync, tooth_evt, gap_evt, err_evt, stall_evt;

  logic        ena8, edge8;
  logic [7:0]  tooth_max8;
  logic [7:0]  period8, period_ref8;
  logic [7:0]  tooth_cnt8;
  logic        sync8, tooth_evt8, gap_evt8, err_evt8, stall_evt8;

  int total = 0;
  int bad = 0;
  int slack = 0;
  int slack8 = 0;

  always #5 clk = ~clk;

  hwag_tooth_tracker dut (
    .clk(clk), .rst(rst), .ena(ena), .edge_in(edge_in), .tooth_max(tooth_max),
    .period(period), .period_ref(period_ref), .tooth_cnt(tooth_cnt), .sync(sync),
    .tooth_evt(tooth_evt), .gap_evt(gap_evt), .err_evt(err_evt), .stall_evt(stall_evt)
  );

  hwag_tooth_tracker #(.CNT_W(8), .TCNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .ena(ena8), .edge_in(edge8), .tooth_max(tooth_max8),
    .period(period8), .period_ref(period_ref8), .tooth_cnt(tooth_cnt8), .sync(sync8),
    .tooth_evt(tooth_evt8), .gap_evt(gap_evt8), .err_evt(err_evt8), .stall_evt(stall_evt8)
  );

  // Edge p cycles after the previous one; returns on the sampling negedge after it.
  task automatic edge_after(input int p);
    repeat (p - 1 - slack) @(negedge clk);
    edge_in = 1'b1;
    @(negedge clk);
    edge_in = 1'b0;
    slack = 0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    slack = slack + n;
  endtask

  task automatic edge8_after(input int p);
    repeat (p - 1 - slack8) @(negedge clk);
    edge8 = 1'b1;
    @(negedge clk);
    edge8 = 1'b0;
    slack8 = 0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    total++; if (period !== 24'd0) begin bad++; $display("FAIL reset_period got=%0d exp=0", period); end
    total++; if (period_ref !== 24'd0) begin bad++; $display("FAIL reset_ref got=%0d exp=0", period_ref); end
    total++; if (tooth_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", tooth_cnt); end
    total++; if ({sync, tooth_evt, gap_evt, err_evt, stall_evt} !== 5'b0) begin
      bad++; $display("FAIL reset_flags got=%b exp=00000", {sync, tooth_evt, gap_evt, err_evt, stall_evt}); end
    total++; if (dut.state_q !== IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", dut.state_q, IDLE); end
    rst = 1'b0;
    slack = 0;
    wait_cyc(1);
    total++; if (dut.state_q !== WAIT_FIRST) begin bad++; $display("FAIL start_wait got=%0d exp=%0d", dut.state_q, WAIT_FIRST); end
  endtask

  task automatic test_startup;
    edge_after(5);
    total++; if ({tooth_evt, gap_evt, err_evt, stall_evt} !== 4'b0) begin
      bad++; $display("FAIL first_edge_pulses got=%b exp=0000", {tooth_evt, gap_evt, err_evt, stall_evt}); end
    total++; if (dut.state_q !== MEASURE) begin bad++; $display("FAIL first_edge_state got=%0d exp=%0d", dut.state_q, MEASURE); end
    edge_after(100);
    total++; if (tooth_evt !== 1'b1) begin bad++; $display("FAIL second_edge_tooth got=%b exp=1", tooth_evt); end
    edge_after(100);
    total++; if (period !== 24'd100) begin bad++; $display("FAIL third_period got=%0d exp=100", period); end
    total++; if (period_ref !== 24'd100) begin bad++; $display("FAIL third_ref got=%0d exp=100", period_ref); end
    total++; if (dut.state_q !== HUNT) begin bad++; $display("FAIL third_state got=%0d exp=%0d", dut.state_q, HUNT); end
    total++; if (sync !== 1'b0) begin bad++; $display("FAIL third_sync got=%b exp=0", sync); end
  endtask

  task automatic test_sync_60_2;
    edge_after(300);
    total++; if ({gap_evt, sync} !== 2'b11) begin bad++; $display("FAIL lock_gap got=%b exp=11", {gap_evt, sync}); end
    total++; if (tooth_cnt !== 8'd0) begin bad++; $display("FAIL lock_cnt got=%0d exp=0", tooth_cnt); end
    total++; if (period !== 24'd300) begin bad++; $display("FAIL lock_period got=%0d exp=300", period); end
    wait_cyc(1);
    total++; if (gap_evt !== 1'b0) begin bad++; $display("FAIL gap_pulse_width got=%b exp=0", gap_evt); end
    for (int i = 1; i <= 57; i++) begin
      edge_after(100);
      total++; if (tooth_cnt !== 8'(i)) begin bad++; $display("FAIL tooth_count got=%0d exp=%0d", tooth_cnt, i); end
    end
    total++; if (sync !== 1'b1) begin bad++; $display("FAIL sync_at_57 got=%b exp=1", sync); end
    edge_after(300);
    total++; if ({gap_evt, err_evt} !== 2'b10) begin bad++; $display("FAIL second_gap got=%b exp=10", {gap_evt, err_evt}); end
    total++; if (tooth_cnt !== 8'd0) begin bad++; $display("FAIL second_gap_cnt got=%0d exp=0", tooth_cnt); end
    total++; if (period_ref !== 24'd100) begin bad++; $display("FAIL second_gap_ref got=%0d exp=100", period_ref); end
  endtask

  task automatic test_bad_gap;
    repeat (20) edge_after(100);
    total++; if (tooth_cnt !== 8'd20) begin bad++; $display("FAIL pre_bad_gap_cnt got=%0d exp=20", tooth_cnt); end
    edge_after(300);
    total++; if ({err_evt, gap_evt, sync} !== 3'b100) begin bad++; $display("FAIL bad_gap got=%b exp=100", {err_evt, gap_evt, sync}); end
    total++; if (dut.state_q !== HUNT) begin bad++; $display("FAIL bad_gap_state got=%0d exp=%0d", dut.state_q, HUNT); end
    repeat (37) edge_after(100);
    edge_after(300);
    total++; if ({gap_evt, sync} !== 2'b11) begin bad++; $display("FAIL resync got=%b exp=11", {gap_evt, sync}); end
    total++; if (tooth_cnt !== 8'd0) begin bad++; $display("FAIL resync_cnt got=%0d exp=0", tooth_cnt); end
  endtask

  task automatic test_missing_gap;
    repeat (57) edge_after(100);
    edge_after(100);
    total++; if ({err_evt, sync} !== 2'b10) begin bad++; $display("FAIL missing_gap got=%b exp=10", {err_evt, sync}); end
    total++; if (period_ref !== 24'd100) begin bad++; $display("FAIL missing_gap_ref got=%0d exp=100", period_ref); end
    total++; if (dut.state_q !== HUNT) begin bad++; $display("FAIL missing_gap_state got=%0d exp=%0d", dut.state_q, HUNT); end
    edge_after(300);
    total++; if (sync !== 1'b1) begin bad++; $display("FAIL missing_resync got=%b exp=1", sync); end
    repeat (5) edge_after(100);
  endtask

  task automatic test_ena_drop;
    ena = 1'b0;
    wait_cyc(1);
    total++; if (sync !== 1'b0) begin bad++; $display("FAIL ena_drop_sync got=%b exp=0", sync); end
    total++; if (dut.state_q !== IDLE) begin bad++; $display("FAIL ena_drop_state got=%0d exp=%0d", dut.state_q, IDLE); end
    edge_after(50);
    total++; if (tooth_evt !== 1'b0) begin bad++; $display("FAIL ena_drop_edge got=%b exp=0", tooth_evt); end
    total++; if (tooth_cnt !== 8'd5) begin bad++; $display("FAIL ena_drop_hold got=%0d exp=5", tooth_cnt); end
    total++; if (period !== 24'd100) begin bad++; $display("FAIL ena_drop_period got=%0d exp=100", period); end
    ena = 1'b1;
    wait_cyc(1);
    total++; if (dut.state_q !== WAIT_FIRST) begin bad++; $display("FAIL reena_state got=%0d exp=%0d", dut.state_q, WAIT_FIRST); end
    total++; if ({period, period_ref, tooth_cnt} !== 56'd0) begin
      bad++; $display("FAIL reena_clear got=%0d/%0d/%0d exp=0/0/0", period, period_ref, tooth_cnt); end
  endtask

  task automatic test_threshold;
    edge_after(10);
    edge_after(100);
    edge_after(150);
    total++; if ({gap_evt, sync} !== 2'b00) begin bad++; $display("FAIL exact_1p5 got=%b exp=00", {gap_evt, sync}); end
    total++; if (period_ref !== 24'd150) begin bad++; $display("FAIL exact_1p5_ref got=%0d exp=150", period_ref); end
    edge_after(226);
    total++; if ({gap_evt, sync} !== 2'b11) begin bad++; $display("FAIL above_1p5 got=%b exp=11", {gap_evt, sync}); end
  endtask

  task automatic test_back_to_back;
    edge_after(1);
    total++; if (period !== 24'd1) begin bad++; $display("FAIL b2b_period got=%0d exp=1", period); end
    total++; if (tooth_cnt !== 8'd1) begin bad++; $display("FAIL b2b_cnt got=%0d exp=1", tooth_cnt); end
    edge_after(1);
    total++; if ({tooth_evt, tooth_cnt} !== {1'b1, 8'd2}) begin
      bad++; $display("FAIL b2b_second got=%b/%0d exp=1/2", tooth_evt, tooth_cnt); end
    tooth_max = 8'd3;
    edge_after(1);
    edge_after(2);
    total++; if ({gap_evt, err_evt, sync} !== 3'b101) begin
      bad++; $display("FAIL tmax_change got=%b exp=101", {gap_evt, err_evt, sync}); end
    total++; if (tooth_cnt !== 8'd0) begin bad++; $display("FAIL tmax_change_cnt got=%0d exp=0", tooth_cnt); end
  endtask

  task automatic test_stall;
    ena8 = 1'b1;
    @(negedge clk);
    slack8 = 1;
    edge8_after(5);
    edge8_after(20);
    edge8_after(60);
    total++; if (sync8 !== 1'b1) begin bad++; $display("FAIL stall_pre_sync got=%b exp=1", sync8); end
    repeat (254) @(negedge clk);
    total++; if (stall_evt8 !== 1'b0 || dut8.state_q !== SYNC) begin
      bad++; $display("FAIL stall_early got=%b/%0d exp=0/%0d", stall_evt8, dut8.state_q, SYNC); end
    @(negedge clk);
    total++; if ({stall_evt8, sync8} !== 2'b10) begin bad++; $display("FAIL stall_pulse got=%b exp=10", {stall_evt8, sync8}); end
    total++; if (dut8.state_q !== WAIT_FIRST) begin bad++; $display("FAIL stall_state got=%0d exp=%0d", dut8.state_q, WAIT_FIRST); end
    @(negedge clk);
    total++; if (stall_evt8 !== 1'b0) begin bad++; $display("FAIL stall_width got=%b exp=0", stall_evt8); end
    slack8 = 0;
    edge8_after(3);
    edge8_after(20);
    edge8_after(60);
    edge8_after(255);
    total++; if ({stall_evt8, tooth_evt8} !== 2'b10) begin bad++; $display("FAIL sat_edge got=%b exp=10", {stall_evt8, tooth_evt8}); end
    total++; if (dut8.state_q !== MEASURE) begin bad++; $display("FAIL sat_edge_state got=%0d exp=%0d", dut8.state_q, MEASURE); end
    edge8_after(30);
    total++; if (period8 !== 8'd30 || dut8.state_q !== HUNT) begin
      bad++; $display("FAIL sat_edge_ref got=%0d/%0d exp=30/%0d", period8, dut8.state_q, HUNT); end
  endtask

  initial begin
    rst = 1'b1;
    ena = 1'b1;
    edge_in = 1'b0;
    tooth_max = 8'd57;
    ena8 = 1'b0;
    edge8 = 1'b0;
    tooth_max8 = 8'd3;
    test_reset();
    test_startup();
    test_sync_60_2();
    test_bad_gap();
    test_missing_gap();
    test_ena_drop();
    test_threshold();
    test_back_to_back();
    test_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
